// File: rtl/timer_pkg.sv
// Shared types and helpers for the stopwatch / countdown timer family.
// Time is carried as minutes (0-15), seconds (0-59), hundredths (0-99).
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [5:0] MAX_SECONDS    = 6'd59;
    localparam logic [6:0] MAX_HUNDREDTHS = 7'd99;

    typedef struct packed {
        logic [3:0] minutes;
        logic [5:0] seconds;
        logic [6:0] hundredths;
    } timer_time_t;

    function automatic int unsigned tick_cycles(input int unsigned frequency);
        return frequency / 100;
    endfunction

    function automatic timer_time_t clamp_time(input logic [3:0] m,
                                               input logic [5:0] s,
                                               input logic [6:0] h);
        timer_time_t t;
        t.minutes    = m;
        t.seconds    = (s > MAX_SECONDS)    ? MAX_SECONDS    : s;
        t.hundredths = (h > MAX_HUNDREDTHS) ? MAX_HUNDREDTHS : h;
        return t;
    endfunction

    function automatic logic is_zero(input timer_time_t t);
        return (t.minutes == 4'd0) && (t.seconds == 6'd0) && (t.hundredths == 7'd0);
    endfunction

    // Borrow chain; callers never pass zero, so minutes cannot wrap.
    function automatic timer_time_t decrement_time(input timer_time_t t);
        timer_time_t r;
        r = t;
        if (t.hundredths != 7'd0) begin
            r.hundredths = t.hundredths - 7'd1;
        end else if (t.seconds != 6'd0) begin
            r.seconds    = t.seconds - 6'd1;
            r.hundredths = MAX_HUNDREDTHS;
        end else begin
            r.minutes    = t.minutes - 4'd1;
            r.seconds    = MAX_SECONDS;
            r.hundredths = MAX_HUNDREDTHS;
        end
        return r;
    endfunction

endpackage

// File: rtl/hundredths_tick_gen.sv
// Divides the system clock down to one enable pulse per 1/100 s.
// The counter holds while disabled so a paused partial tick is preserved.
module hundredths_tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned FREQUENCY = 100_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en_in,
    input  logic clear_in,
    output logic tick_out
);

    localparam int unsigned TICK = tick_cycles(FREQUENCY);
    localparam int unsigned CW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            r_count <= '0;
        end else if (en_in) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

    assign tick_out = en_in && w_at_last;

endmodule

// File: rtl/countdown_timer.sv
// Loadable count-down timer in minutes/seconds/hundredths with pause/resume
// and an expiry flag; all outputs are registered.
module countdown_timer #(
    parameter int unsigned FREQUENCY = 100_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       load_in,
    input  logic [3:0] load_minutes,
    input  logic [5:0] load_seconds,
    input  logic [6:0] load_hundredths,
    input  logic       start_in,
    input  logic       pause_in,
    output logic [3:0] minutes,
    output logic [5:0] seconds,
    output logic [6:0] hundredths,
    output logic       running_out,
    output logic       done_out,
    output logic       expired_out
);

    import timer_pkg::*;

    timer_state_t r_state;
    timer_time_t  r_time;
    logic         r_running;
    logic         r_done;
    logic         r_expired;

    timer_state_t w_state_next;
    timer_time_t  w_time_next;
    timer_time_t  w_time_dec;
    logic         w_tick;
    logic         w_load_accept;
    logic         w_expire;
    logic         w_time_zero;
    logic         w_dec_zero;

    hundredths_tick_gen #(
        .FREQUENCY(FREQUENCY)
    ) u_tick_gen (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en_in   (r_state == RUNNING),
        .clear_in(w_load_accept | w_expire),
        .tick_out(w_tick)
    );

    assign w_time_dec  = decrement_time(r_time);
    assign w_time_zero = is_zero(r_time);
    assign w_dec_zero  = is_zero(w_time_dec);

    // Priority load > pause > start; a pause strobe masks start even where it is ignored.
    always_comb begin
        w_state_next  = r_state;
        w_time_next   = r_time;
        w_load_accept = 1'b0;
        w_expire      = 1'b0;
        case (r_state)
            RUNNING: begin
                if (w_tick) begin
                    w_time_next = w_time_dec;
                    if (w_dec_zero) begin
                        w_state_next = EXPIRED;
                        w_expire     = 1'b1;
                    end else if (pause_in) begin
                        w_state_next = PAUSED;
                    end
                end else if (pause_in) begin
                    w_state_next = PAUSED;
                end
            end
            IDLE, PAUSED: begin
                if (load_in) begin
                    w_load_accept = 1'b1;
                end else if (!pause_in && start_in && !w_time_zero) begin
                    w_state_next = RUNNING;
                end
            end
            EXPIRED: begin
                if (load_in) begin
                    w_load_accept = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_load_accept) begin
            w_time_next  = clamp_time(load_minutes, load_seconds, load_hundredths);
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_time    <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_time    <= w_time_next;
            r_running <= (w_state_next == RUNNING);
            r_done    <= (w_state_next == EXPIRED);
            r_expired <= w_expire;
        end
    end

    assign minutes     = r_time.minutes;
    assign seconds     = r_time.seconds;
    assign hundredths  = r_time.hundredths;
    assign running_out = r_running;
    assign done_out    = r_done;
    assign expired_out = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: total-hundredths reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_countdown_timer;

    localparam int unsigned FREQ = 1000;
    localparam int TICK = 10;

    logic       clk = 1'b0;
    logic       rst, load, start, pause;
    logic [3:0] lm;
    logic [5:0] ls;
    logic [6:0] lh;
    logic [3:0] minutes;
    logic [5:0] seconds;
    logic [6:0] hundredths;
    logic       running_out, done_out, expired_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_timer #(.FREQUENCY(FREQ)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .load_in        (load),
        .load_minutes   (lm),
        .load_seconds   (ls),
        .load_hundredths(lh),
        .start_in       (start),
        .pause_in       (pause),
        .minutes        (minutes),
        .seconds        (seconds),
        .hundredths     (hundredths),
        .running_out    (running_out),
        .done_out       (done_out),
        .expired_out    (expired_out)
    );

    // Model: remaining time as total hundredths; state 0 idle,1 run,2 pause,3 expired.
    int m_state, m_t, m_acc;
    bit m_pulse;
    bit m_valid = 1'b0;

    function automatic int preset_total(input int m, input int s, input int h);
        return m * 6000 + ((s > 59) ? 59 : s) * 100 + ((h > 99) ? 99 : h);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_t = 0; m_acc = 0; m_pulse = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_pulse = 1'b0;
            if (m_state == 1) begin
                m_acc++;
                if (m_acc == TICK) begin
                    m_acc = 0;
                    m_t--;
                    if (m_t == 0) begin
                        m_state = 3;
                        m_pulse = 1'b1;
                    end
                end
                if (m_state == 1 && pause) m_state = 2;
            end else if (load) begin
                m_t = preset_total(int'(lm), int'(ls), int'(lh));
                m_acc = 0;
                m_state = 0;
            end else if (m_state != 3 && !pause && start && m_t != 0) begin
                m_state = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [19:0] got, want;
            got  = {minutes, seconds, hundredths, running_out, done_out, expired_out};
            want = {4'(m_t / 6000), 6'((m_t / 100) % 60), 7'(m_t % 100),
                    m_state == 1, m_state == 3, m_pulse};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL model_cmp t=%0t got m=%0d s=%0d h=%0d r=%b d=%b e=%b required m=%0d s=%0d h=%0d r=%b d=%b e=%b",
                         $time, got[19:16], got[15:10], got[9:3], got[2], got[1], got[0],
                         want[19:16], want[15:10], want[9:3], want[2], want[1], want[0]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic do_load(input int m, input int s, input int h);
        load = 1'b1; lm = 4'(m); ls = 6'(s); lh = 7'(h);
        tick();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
        lm = '0; ls = '0; lh = '0;
        tick();
        tick();
        chk("reset_time", int'({minutes, seconds, hundredths}), 0);
        chk("reset_flags", int'({running_out, done_out, expired_out}), 0);

        // Short countdown to expiry
        do_load(0, 0, 3);
        chk("t1_load_h", hundredths, 3);
        chk("t1_idle", running_out, 0);
        start = 1'b1; tick();
        chk("t1_running", running_out, 1);
        repeat (9) tick();
        chk("t1_h_before_tick", hundredths, 3);
        tick();
        chk("t1_h2", hundredths, 2);
        repeat (10) tick();
        chk("t1_h1", hundredths, 1);
        repeat (9) tick();
        chk("t1_no_early_exp", expired_out, 0);
        tick();
        chk("t1_h0", hundredths, 0);
        chk("t1_expired_pulse", expired_out, 1);
        chk("t1_done", done_out, 1);
        chk("t1_not_running", running_out, 0);
        tick();
        chk("t1_pulse_one_cycle", expired_out, 0);
        chk("t1_done_held", done_out, 1);

        // Borrow chain across minutes and seconds
        do_load(1, 0, 0);
        start = 1'b1; tick();
        repeat (10) tick();
        chk("t2_min", minutes, 0);
        chk("t2_sec", seconds, 59);
        chk("t2_h", hundredths, 99);
        pause = 1'b1; tick();
        do_load(0, 1, 0);
        start = 1'b1; tick();
        repeat (10) tick();
        chk("t2b_sec", seconds, 0);
        chk("t2b_h", hundredths, 99);
        pause = 1'b1; tick();

        // Pause mid-tick keeps the partial tick
        do_load(0, 0, 5);
        start = 1'b1; tick();
        repeat (3) tick();
        pause = 1'b1; tick();
        repeat (50) tick();
        chk("t3_paused_h", hundredths, 5);
        chk("t3_paused_run", running_out, 0);
        start = 1'b1; tick();
        chk("t3_resumed", running_out, 1);
        repeat (5) tick();
        chk("t3_h_hold", hundredths, 5);
        tick();
        chk("t3_h_dec", hundredths, 4);
        pause = 1'b1; tick();

        // Clamping, start at zero, load ignored while running
        do_load(0, 63, 120);
        chk("t4_clamp_s", seconds, 59);
        chk("t4_clamp_h", hundredths, 99);
        do_load(0, 0, 0);
        start = 1'b1; tick();
        chk("t4_zero_start", running_out, 0);
        do_load(0, 0, 50);
        start = 1'b1; tick();
        repeat (4) tick();
        do_load(3, 10, 10);
        chk("t4_load_ignored_m", minutes, 0);
        chk("t4_load_ignored_r", running_out, 1);
        repeat (5) tick();
        chk("t4_continues", hundredths, 49);

        // Same-cycle strobes
        pause = 1'b1; start = 1'b1; tick();
        chk("t5_pause_wins", running_out, 0);
        start = 1'b1; do_load(0, 0, 7);
        chk("t5_load_wins_h", hundredths, 7);
        chk("t5_load_wins_r", running_out, 0);
        do_load(0, 0, 1);
        start = 1'b1; tick();
        repeat (10) tick();
        chk("t5_expired", done_out, 1);
        start = 1'b1; tick();
        chk("t5_exp_start_d", done_out, 1);
        chk("t5_exp_start_r", running_out, 0);

        // Reset mid-tick, then a full tick before the first decrement
        do_load(2, 30, 50);
        start = 1'b1; tick();
        repeat (4) tick();
        rst = 1'b1; tick();
        chk("t6_rst_time", int'({minutes, seconds, hundredths}), 0);
        chk("t6_rst_flags", int'({running_out, done_out, expired_out}), 0);
        do_load(0, 0, 2);
        start = 1'b1; tick();
        repeat (9) tick();
        chk("t6_full_tick_hold", hundredths, 2);
        tick();
        chk("t6_full_tick_dec", hundredths, 1);

        // Randomised strobes, checked by the model every cycle
        repeat (4000) begin
            rst   = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 5) == 0);
            pause = ($urandom_range(0, 11) == 0);
            lm = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            ls = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            lh = 7'($urandom_range(0, 127));
            @(posedge clk);
            #1;
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable count-down counterpart to the stopwatch, using the same minutes/seconds/hundredths format.
- Loads a preset time, then decrements once per 1/100 s while running, with pause and resume.
- Flags expiry when the time reaches 0:00.00.
- Feeds the same display and game logic that consumes stopwatch time.

Parameters:
- FREQUENCY, 100_000_000: clock frequency in Hz. TICK = FREQUENCY/100 cycles per hundredth. FREQUENCY must be a multiple of 100.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- load_in  input  1  one-cycle strobe; load the preset time
- load_minutes  input  4  preset minutes, 0-15
- load_seconds  input  6  preset seconds; values >59 clamp to 59
- load_hundredths  input  7  preset hundredths; values >99 clamp to 99
- start_in  input  1  start or resume strobe
- pause_in  input  1  pause strobe
- minutes  output  4  remaining minutes
- seconds  output  6  remaining seconds, 0-59
- hundredths  output  7  remaining hundredths, 0-99
- running_out  output  1  high while in RUNNING
- done_out  output  1  high while in EXPIRED
- expired_out  output  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, tick counter=0.
  - minutes, seconds and hundredths all 0.
  - running_out, done_out and expired_out all 0.
  - Reset in any state, including mid-tick, aborts immediately.
- All outputs are registered.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Input priority per cycle: rst_in > load_in > pause_in > start_in.
- load_in:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUNNING.
  - Next cycle: time regs hold the clamped preset, tick counter=0, state=IDLE.
- start_in:
  - In IDLE or PAUSED with time != 0: go to RUNNING next cycle.
  - Ignored when time == 0, in RUNNING, and in EXPIRED.
- pause_in:
  - In RUNNING: go to PAUSED next cycle. The tick counter and time are held unchanged, not cleared.
  - Ignored in all other states.
  - pause_in and start_in together in PAUSED: stay PAUSED.
- RUNNING, tick counter:
  - Counter increments each cycle.
  - At TICK-1 it wraps to 0 and the time decrements once.
  - The first decrement is visible TICK cycles after running_out first reads 1.
  - A resume continues from the held counter value, so a paused partial tick is not lost or restarted.
- Decrement (borrow chain):
  - hundredths>0: hundredths-1.
  - Else if seconds>0: seconds-1, hundredths=99.
  - Else: minutes-1, seconds=59, hundredths=99.
  - No underflow is possible; time 0 is never decremented.
- Expiry:
  - When a decrement produces 0:00.00, the state moves to EXPIRED in the same update.
  - In that cycle: time reads zero, expired_out=1 for exactly one cycle, done_out=1 and running_out=0.
- EXPIRED:
  - Held until load_in or rst_in.
  - Counter stays 0 and time stays 0.
- Maximum preset 15:59.99. The output encoding is identical to the stopwatch outputs.

Decomposition:
- Package timer_pkg:
  - timer_state_t enum (IDLE, RUNNING, PAUSED, EXPIRED).
  - Constants MAX_SECONDS=59 and MAX_HUNDREDTHS=99.
  - Function tick_cycles(FREQUENCY) returning FREQUENCY/100.
  - Shared with the stopwatch.
- Sub-module hundredths_tick_gen:
  - Parameterised on FREQUENCY.
  - Inputs: en_in (hold when low), clear_in (zero the counter).
  - Output: tick_out, high in the cycle the counter equals TICK-1 while en_in=1.
  - countdown_timer drives en_in=running and clear_in=load|expiry.

Test Plan (FREQUENCY=1000, so TICK=10):
- Load 0:00.03, start → running_out=1 next cycle; hundredths reads 2, 1, 0 at +10, +20, +30 cycles; expired_out high exactly 1 cycle at +30; done_out stays 1; running_out=0.
- Load 1:00.00, start, run 1 tick → time reads 0:59.99; load 0:01.00, run 1 tick → 0:00.99.
- Load 0:00.05, start, pause at 4 cycles into the tick, hold PAUSED 50 cycles (time unchanged at 0:00.05), start → decrement to 0:00.04 exactly 6 cycles after running_out re-asserts.
- Load seconds=63, hundredths=120 → reads 0:59.99. Start with time 0 → stays IDLE, running_out=0. load_in during RUNNING → ignored, countdown continues.
- Same-cycle pause_in+start_in in RUNNING → PAUSED. load_in+start_in in IDLE → load only, stays IDLE. start_in in EXPIRED → no change.
- rst_in mid-tick in RUNNING at 2:30.50 → next cycle all outputs 0, state IDLE. Subsequent load+start counts a full TICK before the first decrement.
